// File: rtl/ternary_operand_sequencer.sv
// Splits an input byte stream into a ternary weight bank and row-indexed int8
// activation pairs for the ternary matrix-vector multiplier.
module ternary_operand_sequencer #(
    parameter int InLen    = 16,
    parameter int OutLen   = 8,
    parameter int BitWidth = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_vld,
    input  logic                          wsel,
    output logic [2*InLen*OutLen-1:0]     W,
    output logic [2*BitWidth-1:0]         VecIn,
    output logic [$clog2(InLen/2)-1:0]    row,
    output logic                          en,
    output logic                          w_ready,
    output logic                          drop_err
);
    localparam int WBits  = 2 * InLen * OutLen;
    localparam int WBytes = WBits / 8;
    localparam int WCntW  = $clog2(WBytes);
    localparam int Rows   = InLen / 2;
    localparam int RowW   = $clog2(Rows);

    localparam logic [WCntW-1:0] WCntLast = WCntW'(WBytes - 1);
    localparam logic [RowW-1:0]  RowLast  = RowW'(Rows - 1);

    logic [WBits-1:0]      w_q, w_d;
    logic [WCntW-1:0]      wcnt_q, wcnt_d;
    logic                  w_ready_q, w_ready_d;
    logic                  hi_pend_q, hi_pend_d;
    logic [BitWidth-1:0]   act_hi_q, act_hi_d;
    logic [2*BitWidth-1:0] vec_q, vec_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [RowW-1:0]       pair_idx_q, pair_idx_d;
    logic                  frame_seen_q, frame_seen_d;
    logic                  en_q, en_d;
    logic                  drop_err_q, drop_err_d;

    always_comb begin
        w_d          = w_q;
        wcnt_d       = wcnt_q;
        w_ready_d    = w_ready_q;
        hi_pend_d    = hi_pend_q;
        act_hi_d     = act_hi_q;
        vec_d        = vec_q;
        row_d        = row_q;
        pair_idx_d   = pair_idx_q;
        frame_seen_d = frame_seen_q;
        en_d         = 1'b0;
        drop_err_d   = drop_err_q;

        if (data_vld && wsel) begin
            w_d[8*wcnt_q +: 8] = data_in;
            wcnt_d             = wcnt_q + WCntW'(1);
            // A load starting from byte 0 invalidates the bank until byte 31 lands.
            if (wcnt_q == '0)
                w_ready_d = 1'b0;
            if (wcnt_q == WCntLast)
                w_ready_d = 1'b1;
            hi_pend_d = 1'b0;
        end else if (data_vld) begin
            if (!w_ready_q) begin
                drop_err_d = 1'b1;
            end else if (!hi_pend_q) begin
                act_hi_d  = data_in[BitWidth-1:0];
                hi_pend_d = 1'b1;
            end else begin
                vec_d      = {act_hi_q, data_in[BitWidth-1:0]};
                row_d      = pair_idx_q;
                hi_pend_d  = 1'b0;
                pair_idx_d = pair_idx_q + RowW'(1);
                // Latch strobe only once a complete frame is behind us.
                en_d       = (pair_idx_q == '0) && frame_seen_q;
                if (pair_idx_q == RowLast)
                    frame_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q          <= '0;
            wcnt_q       <= '0;
            w_ready_q    <= 1'b0;
            hi_pend_q    <= 1'b0;
            act_hi_q     <= '0;
            vec_q        <= '0;
            row_q        <= '0;
            pair_idx_q   <= '0;
            frame_seen_q <= 1'b0;
            en_q         <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            w_q          <= w_d;
            wcnt_q       <= wcnt_d;
            w_ready_q    <= w_ready_d;
            hi_pend_q    <= hi_pend_d;
            act_hi_q     <= act_hi_d;
            vec_q        <= vec_d;
            row_q        <= row_d;
            pair_idx_q   <= pair_idx_d;
            frame_seen_q <= frame_seen_d;
            en_q         <= en_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign W        = w_q;
    assign VecIn    = vec_q;
    assign row      = row_q;
    assign en       = en_q;
    assign w_ready  = w_ready_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_ternary_operand_sequencer.sv
// Bench for ternary_operand_sequencer: directed scenarios plus randomized
// traffic against a byte/pair-count reference model.
module tb_ternary_operand_sequencer;
    logic         clk;
    logic         rst;
    logic [7:0]   data_in;
    logic         data_vld;
    logic         wsel;
    logic [255:0] W;
    logic [15:0]  VecIn;
    logic [2:0]   row;
    logic         en;
    logic         w_ready;
    logic         drop_err;

    int checks = 0;
    int errors = 0;

    ternary_operand_sequencer dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld), .wsel(wsel),
        .W(W), .VecIn(VecIn), .row(row), .en(en), .w_ready(w_ready), .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    // Reference model: weight bytes by index, pairs counted since reset.
    logic [7:0]  wbytes [32];
    int          wcount;
    int          npairs;
    logic        exp_rdy;
    logic        pend;
    logic [7:0]  pend_byte;
    logic [15:0] exp_vec;
    logic [2:0]  exp_row;
    logic        exp_en;
    logic        exp_drop;

    logic [277:0] obs;
    assign obs = {W, VecIn, row, en, w_ready, drop_err};

    function automatic logic [277:0] exp_bus();
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[8*i +: 8] = wbytes[i];
        return {w, exp_vec, exp_row, exp_en, exp_rdy, exp_drop};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) wbytes[i] = 8'h00;
        wcount = 0; npairs = 0; exp_rdy = 0; pend = 0; pend_byte = 0;
        exp_vec = 0; exp_row = 0; exp_en = 0; exp_drop = 0;
    endtask

    task automatic model_step(input logic ws, input logic [7:0] b);
        exp_en = 0;
        if (ws) begin
            if (wcount == 0) exp_rdy = 0;
            wbytes[wcount] = b;
            wcount = (wcount + 1) % 32;
            if (wcount == 0) exp_rdy = 1;
            pend = 0;
        end else if (!exp_rdy) begin
            exp_drop = 1;
        end else if (!pend) begin
            pend = 1;
            pend_byte = b;
        end else begin
            exp_vec = {pend_byte, b};
            exp_row = 3'(npairs % 8);
            exp_en  = (npairs % 8 == 0) && (npairs >= 8);
            npairs++;
            pend = 0;
        end
    endtask

    task automatic send(input logic ws, input logic [7:0] b);
        @(negedge clk);
        data_vld = 1'b1; wsel = ws; data_in = b;
        @(posedge clk);
        model_step(ws, b);
        #1;
        data_vld = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        data_vld = 1'b0;
        @(posedge clk);
        exp_en = 0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; data_vld = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({VecIn, row, en, w_ready, drop_err} !== 23'd0 || W !== 256'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0", obs);
        end
    endtask

    task automatic test_weight_load();
        for (int i = 0; i < 32; i++) begin
            send(1'b1, 8'(i));
            checks++;
            if (w_ready !== (i == 31)) begin
                errors++;
                $display("FAIL wload_ready byte=%0d got=%b expected=%b", i, w_ready, (i == 31));
            end
        end
        checks++;
        if (W[7:0] !== 8'h00 || W[255:248] !== 8'h1F) begin
            errors++;
            $display("FAIL wload_ends got=%h/%h expected=00/1f", W[7:0], W[255:248]);
        end
        checks++;
        if (obs !== exp_bus()) begin
            errors++;
            $display("FAIL wload_bus got=%h expected=%h", obs, exp_bus());
        end
    endtask

    task automatic test_first_frame();
        logic [7:0] a, b;
        for (int k = 0; k < 8; k++) begin
            a = 8'(2*k + 1);
            b = 8'(2*k + 2);
            send(1'b0, a);
            send(1'b0, b);
            checks++;
            if (VecIn !== {a, b} || row !== 3'(k) || en !== 1'b0) begin
                errors++;
                $display("FAIL frame1_pair%0d got=%h/%0d/%b expected=%h/%0d/0", k, VecIn, row, en, {a, b}, k);
            end
        end
    endtask

    task automatic test_second_frame_en();
        logic [7:0] a, b;
        for (int k = 0; k < 8; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            send(1'b0, a);
            checks++;
            if (en !== 1'b0) begin
                errors++;
                $display("FAIL frame2_hi_en pair=%0d got=%b expected=0", k, en);
            end
            send(1'b0, b);
            checks++;
            if (VecIn !== {a, b} || row !== 3'(k) || en !== (k == 0)) begin
                errors++;
                $display("FAIL frame2_pair%0d got=%h/%0d/%b expected=%h/%0d/%b", k, VecIn, row, en, {a, b}, k, (k == 0));
            end
        end
        idle();
        checks++;
        if (obs !== exp_bus()) begin
            errors++;
            $display("FAIL frame2_idle got=%h expected=%h", obs, exp_bus());
        end
    endtask

    task automatic test_drop_before_weights();
        do_reset();
        send(1'b0, 8'h55);
        checks++;
        if (drop_err !== 1'b1 || VecIn !== 16'h0000 || row !== 3'd0) begin
            errors++;
            $display("FAIL drop_no_weights got=%b/%h/%0d expected=1/0000/0", drop_err, VecIn, row);
        end
    endtask

    task automatic test_partial_discard();
        for (int i = 0; i < 32; i++) send(1'b1, 8'($urandom));
        send(1'b0, 8'h7F);
        for (int i = 0; i < 32; i++) send(1'b1, 8'($urandom));
        send(1'b0, 8'h80);
        send(1'b0, 8'h81);
        checks++;
        if (VecIn !== 16'h8081 || row !== 3'd0) begin
            errors++;
            $display("FAIL partial_discard got=%h/%0d expected=8081/0", VecIn, row);
        end
        checks++;
        if (obs !== exp_bus()) begin
            errors++;
            $display("FAIL partial_bus got=%h expected=%h", obs, exp_bus());
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 1; k <= 4; k++) begin
            send(1'b0, 8'($urandom));
            send(1'b0, 8'($urandom));
        end
        checks++;
        if (row !== 3'd4) begin
            errors++;
            $display("FAIL midframe_row got=%0d expected=4", row);
        end
        do_reset();
        checks++;
        if ({VecIn, row, en, w_ready, drop_err} !== 23'd0 || W !== 256'd0) begin
            errors++;
            $display("FAIL midframe_reset got=%h expected=0", obs);
        end
        for (int i = 0; i < 32; i++) send(1'b1, 8'($urandom));
        for (int k = 0; k < 9; k++) begin
            send(1'b0, 8'($urandom));
            send(1'b0, 8'($urandom));
            checks++;
            if (en !== (k == 8) || row !== 3'(k % 8)) begin
                errors++;
                $display("FAIL midframe_en pair=%0d got=%b/%0d expected=%b/%0d", k, en, row, (k == 8), k % 8);
            end
        end
    endtask

    task automatic test_random();
        logic ws;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 10) begin
                idle();
            end else begin
                ws = !exp_rdy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 49) == 0);
                send(ws, 8'($urandom));
            end
            checks++;
            if (obs !== exp_bus()) begin
                errors++;
                $display("FAIL random_bus step=%0d got=%h expected=%h", n, obs, exp_bus());
            end
            checks++;
            if (en === 1'b1 && row !== 3'd0) begin
                errors++;
                $display("FAIL random_en_row step=%0d got=%0d expected=0", n, row);
            end
        end
    endtask

    initial begin
        rst = 1'b0; data_vld = 1'b0; wsel = 1'b0; data_in = 8'h00;
        model_reset();
        test_reset();
        test_weight_load();
        test_first_frame();
        test_second_frame_en();
        test_drop_before_weights();
        test_partial_discard();
        test_reset_midframe();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
